// File: rtl/updown_pkg.sv
// Shared definitions for the guess/compare interface.
// Comparison encodings, value limits and FSM states.
package updown_pkg;

    localparam int NUM_W   = 7;
    localparam int MAX_VAL = 99;

    localparam logic [1:0] CMP_EQUAL = 2'b00;
    localparam logic [1:0] CMP_UP    = 2'b01;
    localparam logic [1:0] CMP_DOWN  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_COMPARE,
        S_EMIT,
        S_HOLD,
        S_DONE
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level
// debounce counter and a one-cycle rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Flip the level only after a run of consecutive differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/guess_unit.sv
// Guess producer: secret generation, press handling, compare
// and one-cycle guess_trigger toward game_control.
module guess_unit
    import updown_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_W-1:0] switch_in,
    input  logic             submit_btn,
    input  logic             game_over,
    output logic [1:0]       comparison_result,
    output logic             guess_trigger,
    output logic             invalid_guess,
    output logic             secret_valid,
    output logic [NUM_W-1:0] secret_out
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_lfsr;
    logic [NUM_W-1:0] r_guess;
    logic [NUM_W-1:0] r_secret;
    logic             r_secret_valid;
    logic [1:0]       r_result;
    logic             r_trig;
    logic             r_inv;

    logic             w_level;
    logic             w_press;
    logic             w_fb;
    logic [NUM_W-1:0] w_red;
    logic [NUM_W-1:0] w_secret_nxt;
    logic             w_capture;
    logic             w_latch;
    logic             w_out_of_range;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (reset),
        .i_raw  (submit_btn),
        .o_level(w_level),
        .o_press(w_press)
    );

    assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_red = NUM_W'(r_lfsr[6:0]);
    assign w_secret_nxt = (w_red > NUM_W'(MAX_VAL))
                        ? w_red - NUM_W'(MAX_VAL + 1)
                        : w_red;
    assign w_out_of_range = r_guess > NUM_W'(MAX_VAL);

    // Free-running LFSR; the timing of the first press picks the secret.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_lfsr <= LFSR_SEED;
        else        r_lfsr <= {r_lfsr[6:0], w_fb};
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; game_over outranks a simultaneous press.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_latch     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_capture   = 1'b1;
                    w_latch     = 1'b1;
                    w_state_nxt = S_COMPARE;
                end
            end
            S_ARMED: begin
                if (game_over) begin
                    w_state_nxt = S_DONE;
                end else if (w_press) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                w_state_nxt = w_out_of_range ? S_HOLD : S_EMIT;
            end
            S_EMIT: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (game_over)     w_state_nxt = S_DONE;
                else if (!w_level) w_state_nxt = S_ARMED;
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Guess/secret capture, registered compare result and output pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_guess        <= '0;
            r_secret       <= '0;
            r_secret_valid <= 1'b0;
            r_result       <= CMP_EQUAL;
            r_trig         <= 1'b0;
            r_inv          <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            r_inv  <= 1'b0;
            if (w_latch) r_guess <= switch_in;
            if (w_capture) begin
                r_secret       <= w_secret_nxt;
                r_secret_valid <= 1'b1;
            end
            if (r_state == S_COMPARE) begin
                if (w_out_of_range) begin
                    r_inv <= 1'b1;
                end else begin
                    r_trig <= 1'b1;
                    if (r_guess == r_secret)     r_result <= CMP_EQUAL;
                    else if (r_guess < r_secret) r_result <= CMP_UP;
                    else                         r_result <= CMP_DOWN;
                end
            end
        end
    end

    assign comparison_result = r_result;
    assign guess_trigger     = r_trig;
    assign invalid_guess     = r_inv;
    assign secret_valid      = r_secret_valid;
    assign secret_out        = r_secret;

endmodule

// File: tb/tb_guess_unit.sv
// Directed bench for guess_unit with a reference LFSR model
// used to predict the captured secret.
module tb_guess_unit;
    import updown_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] switch_in = '0;
    logic       submit_btn = 1'b0;
    logic       game_over = 1'b0;
    logic [1:0] comparison_result;
    logic       guess_trigger;
    logic       invalid_guess;
    logic       secret_valid;
    logic [6:0] secret_out;

    guess_unit #(
        .DEBOUNCE_CYCLES(4),
        .LFSR_SEED      (8'hA5)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .switch_in        (switch_in),
        .submit_btn       (submit_btn),
        .game_over        (game_over),
        .comparison_result(comparison_result),
        .guess_trigger    (guess_trigger),
        .invalid_guess    (invalid_guess),
        .secret_valid     (secret_valid),
        .secret_out       (secret_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int trig_cnt = 0;
    int inv_cnt  = 0;
    int sv_cnt   = 0;

    logic [7:0] m_lfsr;

    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    always @(negedge clk) begin
        trig_cnt += int'(guess_trigger);
        inv_cnt  += int'(invalid_guess);
        sv_cnt   += int'(secret_valid);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] red(input logic [7:0] v);
        logic [6:0] r;
        r = v[6:0];
        return (r > 7'd99) ? r - 7'd100 : r;
    endfunction

    function automatic logic [1:0] exp_cmp(input logic [6:0] g,
                                           input logic [6:0] s);
        if (g == s) return CMP_EQUAL;
        if (g < s)  return CMP_UP;
        return CMP_DOWN;
    endfunction

    // Hold the button 30 cycles, then release and settle 20 cycles.
    // lat = negedge index (after the drive) of the first output pulse.
    task automatic press(input logic [6:0] sw, input bit set_over,
                         output int trigs, output int invs,
                         output int lat, output logic [6:0] cap);
        int t0;
        int i0;
        @(negedge clk);
        switch_in  = sw;
        submit_btn = 1'b1;
        t0  = trig_cnt;
        i0  = inv_cnt;
        lat = -1;
        cap = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 6) cap = red(m_lfsr);
            if ((guess_trigger || invalid_guess) && lat < 0) begin
                lat = i;
                if (set_over) game_over = 1'b1;
            end
        end
        submit_btn = 1'b0;
        repeat (20) @(negedge clk);
        trigs = trig_cnt - t0;
        invs  = inv_cnt - i0;
    endtask

    initial begin
        int         tr;
        int         iv;
        int         lat;
        int         t0;
        int         s0;
        logic [6:0] cap;
        logic [6:0] s;
        logic [6:0] g_tab [4];
        logic [6:0] bad_tab [2];

        repeat (5) @(negedge clk);
        check("rst_result", 32'(comparison_result), 32'(CMP_EQUAL));
        check("rst_trig", 32'(guess_trigger), 0);
        check("rst_inv", 32'(invalid_guess), 0);
        check("rst_sv", 32'(secret_valid), 0);
        check("rst_secret", 32'(secret_out), 0);
        reset = 1'b1;
        t0 = trig_cnt;
        s0 = sv_cnt;
        repeat (100) @(negedge clk);
        check("idle_no_trig", 32'(trig_cnt - t0), 0);
        check("idle_no_sv", 32'(sv_cnt - s0), 0);

        press(7'd0, 1'b0, tr, iv, lat, cap);
        s = cap;
        check("first_trig", 32'(tr), 1);
        check("first_lat", 32'(lat), 8);
        check("first_sv", 32'(secret_valid), 1);
        check("first_secret", 32'(secret_out), 32'(s));
        check("first_result", 32'(comparison_result), 32'(exp_cmp(7'd0, s)));

        g_tab = '{7'd99, 7'd50, 7'd1, s};
        foreach (g_tab[k]) begin
            press(g_tab[k], 1'b0, tr, iv, lat, cap);
            check("guess_trig", 32'(tr), 1);
            check("guess_inv", 32'(iv), 0);
            check("guess_lat", 32'(lat), 8);
            check("guess_result", 32'(comparison_result),
                  32'(exp_cmp(g_tab[k], s)));
        end

        bad_tab = '{7'd100, 7'd127};
        foreach (bad_tab[k]) begin
            press(bad_tab[k], 1'b0, tr, iv, lat, cap);
            check("bad_inv", 32'(iv), 1);
            check("bad_trig", 32'(tr), 0);
            check("bad_lat", 32'(lat), 8);
            check("bad_result", 32'(comparison_result), 32'(CMP_EQUAL));
        end

        @(negedge clk);
        switch_in = 7'd99;
        t0 = trig_cnt;
        for (int k = 0; k < 5; k++) begin
            submit_btn = 1'b1;
            repeat (2) @(negedge clk);
            submit_btn = 1'b0;
            repeat (2) @(negedge clk);
        end
        check("bounce_none", 32'(trig_cnt - t0), 0);
        submit_btn = 1'b1;
        repeat (1000) @(negedge clk);
        check("bounce_one", 32'(trig_cnt - t0), 1);
        check("bounce_result", 32'(comparison_result),
              32'(exp_cmp(7'd99, s)));
        submit_btn = 1'b0;
        repeat (20) @(negedge clk);

        press(s, 1'b1, tr, iv, lat, cap);
        check("over_trig", 32'(tr), 1);
        t0 = trig_cnt;
        s0 = inv_cnt;
        press(7'd10, 1'b0, tr, iv, lat, cap);
        press(7'd120, 1'b0, tr, iv, lat, cap);
        press(s, 1'b0, tr, iv, lat, cap);
        check("done_no_trig", 32'(trig_cnt - t0), 0);
        check("done_no_inv", 32'(inv_cnt - s0), 0);
        check("done_sv", 32'(secret_valid), 1);
        check("done_secret", 32'(secret_out), 32'(s));

        reset = 1'b0;
        #1;
        check("rst2_sv", 32'(secret_valid), 0);
        check("rst2_secret", 32'(secret_out), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        game_over = 1'b0;
        repeat (5) @(negedge clk);
        press(7'd0, 1'b0, tr, iv, lat, cap);
        check("regen_trig", 32'(tr), 1);
        check("regen_secret", 32'(secret_out), 32'(cap));
        check("regen_result", 32'(comparison_result),
              32'(exp_cmp(7'd0, cap)));

        @(negedge clk);
        switch_in  = 7'd5;
        submit_btn = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_trig", 32'(guess_trigger), 0);
        check("midrst_inv", 32'(invalid_guess), 0);
        check("midrst_sv", 32'(secret_valid), 0);
        check("midrst_secret", 32'(secret_out), 0);
        check("midrst_result", 32'(comparison_result), 32'(CMP_EQUAL));
        t0 = trig_cnt;
        repeat (3) @(negedge clk);
        submit_btn = 1'b0;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_dropped", 32'(trig_cnt - t0), 0);
        check("midrst_idle_sv", 32'(secret_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
